// File: rtl/ask4_symbol_source.sv
// 4-ASK pseudo-random symbol source feeding the pulse-shaping filter x_in.
// 22-bit Fibonacci LFSR (x^22+x^21+1), Gray-mapped to 1s17 levels, upsampled by 4.
//
// state     | meaning
// IDLE      | output 0 on every sample, LFSR frozen
// PN_STUFF  | symbol on sym_clk_en samples, zero on the other samples
// PN_HOLD   | symbol on sym_clk_en samples, previous value held otherwise
// IMP_ARMED | first sample of a mode-2 entry: emits IMP_AMP once
// IMP_DONE  | impulse already issued, output 0 until mode 2 is left and re-entered
module ask4_symbol_source #(
  parameter logic        [21:0] SEED    = 22'h3FFFFF,
  parameter logic signed [17:0] LVL_HI  = 18'sd98304,
  parameter logic signed [17:0] LVL_LO  = 18'sd32768,
  parameter logic signed [17:0] IMP_AMP = 18'sd131071
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic [1:0]         mode,
  output logic signed [17:0] x_out,
  output logic [1:0]         sym_out,
  output logic               sym_valid,
  output logic               lfsr_wrap
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PN_STUFF  = 3'd1,
    PN_HOLD   = 3'd2,
    IMP_ARMED = 3'd3,
    IMP_DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  mode_q;
  logic [21:0] lfsr;
  logic [21:0] lfsr_s1;
  logic [21:0] lfsr_s2;
  logic [1:0]  sym_cur;
  logic signed [17:0] level;
  logic        pn_nx;
  logic        advance;

  // mode_q is the mode seen at the previous sample; it gates impulse re-arming.
  always_comb begin
    state_nx = state;
    case (mode)
      2'd0: state_nx = PN_STUFF;
      2'd1: state_nx = PN_HOLD;
      2'd2: state_nx = (mode_q != 2'd2) ? IMP_ARMED : IMP_DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    lfsr_s1 = {lfsr[20:0], lfsr[21] ^ lfsr[20]};
    lfsr_s2 = {lfsr_s1[20:0], lfsr_s1[21] ^ lfsr_s1[20]};
    sym_cur = lfsr[21:20];
    level   = '0;
    case (sym_cur)
      2'b00: level = -LVL_HI;
      2'b01: level = -LVL_LO;
      2'b11: level = LVL_LO;
      default: level = LVL_HI;
    endcase
    pn_nx   = (state_nx == PN_STUFF) || (state_nx == PN_HOLD);
    advance = sam_clk_en && sym_clk_en && pn_nx;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 2'd3;
      lfsr      <= SEED;
      x_out     <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      lfsr_wrap <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      lfsr_wrap <= 1'b0;
      if (sam_clk_en) begin
        mode_q <= mode;
        state  <= state_nx;
        case (state_nx)
          PN_STUFF:  x_out <= sym_clk_en ? level : '0;
          PN_HOLD:   if (sym_clk_en) x_out <= level;
          IMP_ARMED: x_out <= IMP_AMP;
          default:   x_out <= '0;
        endcase
        if (advance) begin
          lfsr      <= lfsr_s2;
          sym_out   <= sym_cur;
          sym_valid <= 1'b1;
          lfsr_wrap <= (lfsr_s2 == SEED);
        end
      end
    end
  end

endmodule

// File: tb/tb_ask4_symbol_source.sv
// Scoreboard bench for ask4_symbol_source: a bit-queue PN model predicts every sample,
// a separate monitor pops and compares on each post-strobe cycle.
module tb_ask4_symbol_source;

  logic               sys_clk = 1'b0;
  logic               rst = 1'b1;
  logic               sam_clk_en = 1'b0;
  logic               sym_clk_en = 1'b0;
  logic [1:0]         mode = 2'd3;
  logic signed [17:0] x_out;
  logic [1:0]         sym_out;
  logic               sym_valid;
  logic               lfsr_wrap;

  ask4_symbol_source dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .mode       (mode),
    .x_out      (x_out),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .lfsr_wrap  (lfsr_wrap)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int       x;
    bit       sv;
    bit [1:0] sy;
    bit       wr;
  } rec_t;

  rec_t sbq[$];
  int   total = 0;
  int   bad = 0;

  // model state: the last 22 bits of the PN bit stream, oldest first
  bit   pnq[$];
  bit   seedq[$];
  int   m_last_x;
  bit [1:0] m_last_sym;
  logic [1:0] m_prev_mode;
  int   ph;
  int   n_sym;
  int   first_sym_x;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gray_level(bit [1:0] s);
    case (s)
      2'b00: return -98304;
      2'b01: return -32768;
      2'b11: return 32768;
      default: return 98304;
    endcase
  endfunction

  task automatic model_reset();
    logic [21:0] sd;
    sd = 22'h3FFFFF;
    pnq.delete();
    seedq.delete();
    for (int i = 21; i >= 0; i--) begin
      pnq.push_back(sd[i]);
      seedq.push_back(sd[i]);
    end
    m_last_x    = 0;
    m_last_sym  = 2'b00;
    m_prev_mode = 2'd3;
  endtask

  task automatic model_sample(bit sym, logic [1:0] m);
    rec_t r;
    bit nb;
    bit same;
    r.sv = 0;
    r.wr = 0;
    r.x  = 0;
    case (m)
      2'd0, 2'd1: begin
        if (sym) begin
          m_last_sym = {pnq[0], pnq[1]};
          for (int k = 0; k < 2; k++) begin
            nb = pnq[0] ^ pnq[1];
            void'(pnq.pop_front());
            pnq.push_back(nb);
          end
          same = 1;
          for (int k = 0; k < 22; k++) if (pnq[k] != seedq[k]) same = 0;
          r.x  = gray_level(m_last_sym);
          r.sv = 1;
          r.wr = same;
          n_sym++;
          if (n_sym == 1) first_sym_x = r.x;
        end else begin
          r.x = (m == 2'd0) ? 0 : m_last_x;
        end
      end
      2'd2: r.x = (m_prev_mode != 2'd2) ? 131071 : 0;
      default: r.x = 0;
    endcase
    r.sy = m_last_sym;
    m_last_x = r.x;
    m_prev_mode = m;
    sbq.push_back(r);
  endtask

  task automatic cyc(bit sam, bit sym, logic [1:0] m);
    sam_clk_en = sam;
    sym_clk_en = sym;
    mode = m;
    if (sam && !rst) model_sample(sym, m);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset(logic [1:0] m);
    rst = 1'b1;
    sam_clk_en = 1'($urandom_range(0, 1));
    sym_clk_en = sam_clk_en;
    mode = m;
    model_reset();
    n_sym = 0;
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    ph = 0;
  endtask

  // sam every 4 sys_clk, sym on every 4th sam; mode may wander between strobes
  task automatic run_reg(int nsam, logic [1:0] m);
    for (int i = 0; i < nsam; i++) begin
      cyc(1'b1, ph == 3, m);
      ph = (ph + 1) % 4;
      for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0, (j == 1) ? 2'($urandom) : m);
    end
  endtask

  // monitor
  bit   sam_d = 0;
  bit   rst_d = 0;
  int   mon_x = 0;

  always @(posedge sys_clk) begin
    rst_d <= rst;
    sam_d <= sam_clk_en & ~rst;
  end

  always @(negedge sys_clk) begin
    rec_t r;
    if (rst_d) begin
      chk("rst_x_out", int'(x_out), 0);
      chk("rst_sym_valid", int'(sym_valid), 0);
      chk("rst_lfsr_wrap", int'(lfsr_wrap), 0);
      chk("rst_sym_out", int'(sym_out), 0);
      mon_x = 0;
    end else if (sam_d) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        r = sbq.pop_front();
        chk("x_out", int'(x_out), r.x);
        chk("sym_valid", int'(sym_valid), int'(r.sv));
        chk("sym_out", int'(sym_out), int'(r.sy));
        chk("lfsr_wrap", int'(lfsr_wrap), int'(r.wr));
        mon_x = r.x;
      end
    end else begin
      chk("x_hold", int'(x_out), mon_x);
      chk("idle_sym_valid", int'(sym_valid), 0);
      chk("idle_lfsr_wrap", int'(lfsr_wrap), 0);
    end
  end

  initial begin
    int scnt;
    bit s, y;
    logic [1:0] m;
    model_reset();
    n_sym = 0;
    first_sym_x = 0;
    ph = 0;
    @(posedge sys_clk);
    #1;
    do_reset(2'd0);

    // zero-stuffed PN, 1000 symbols
    run_reg(4000, 2'd0);
    chk("first_symbol_level", first_sym_x, 32768);

    // held PN
    run_reg(800, 2'd1);

    // impulse: idle, arm, hold, leave, re-arm
    run_reg(10, 2'd3);
    run_reg(12, 2'd2);
    run_reg(2, 2'd3);
    run_reg(12, 2'd2);
    run_reg(3, 2'd0);
    run_reg(6, 2'd2);

    // reset with mode 2 held arms an impulse on the first sample
    do_reset(2'd2);
    run_reg(6, 2'd2);

    // random strobes, including sym_clk_en without sam_clk_en
    scnt = 0;
    m = 2'd0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 49) == 0) m = 2'($urandom);
      s = ($urandom_range(0, 2) == 0);
      y = s ? (scnt % 4 == 3) : ($urandom_range(0, 3) == 0);
      cyc(s, y, m);
      if (s) scnt++;
    end

    // reset mid PN stream restarts the sequence
    do_reset(2'd0);
    run_reg(40, 2'd0);
    do_reset(2'd1);
    run_reg(40, 2'd1);
    chk("restart_first_symbol", first_sym_x, 32768);

    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'd3);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
